pipe_alu: RTL and testbench

Parametrised, handshaked execute-stage ALU for the pipeline processor: the successor to the single-cycle combinational ALU. It registers its result behind a valid/ready interface and adds signed/unsigned compare, XOR, arithmetic shift and full carry/overflow flags. A WIDTH-cycle iterative multiplier returns the low or high product half. A tag travels with each operation so the writeback stage can match results to destination registers.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/pipe_alu.sv | 153 +++++++++++++++
 tb/tb_pipe_alu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU.
// Opcode and handshake-state encodings plus small helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_SRL   = 4'd3,
    OP_SLL   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_SLT   = 4'd7,
    OP_SLTU  = 4'd8,
    OP_XOR   = 4'd9,
    OP_SRA   = 4'd10,
    OP_MULHU = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_e;

  function automatic logic is_mul(op_e op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// product shows the value the register takes at this edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH:0]   sum;

  // {acc, mq} is the 2*WIDTH product register; mq shifts out multiplier bits
  assign sum     = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign product = {sum, mq[WIDTH-1:1]};
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
    end else if (flush) begin
      busy  <= 1'b0;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= '0;
      mq    <= b;
    end else if (busy) begin
      {acc, mq} <= product;
      cnt       <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Handshaked execute-stage ALU with registered result and flags.
// MUL/MULHU run on the iterative multiplier; all else is one cycle.
module pipe_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_carry,
  output logic                     out_ovf
);

  state_e state, state_n;
  op_e    op;
  logic   acc;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;

  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_hi;
  logic [TAG_W-1:0]   mul_tag;

  assign op        = op_e'(in_op);
  assign in_ready  = (state == IDLE) || ((state == RESP) && out_ready);
  assign acc       = in_valid && in_ready && !flush;
  assign out_valid = (state == RESP);
  assign mul_res   = mul_hi ? mul_prod[2*WIDTH-1:WIDTH]
                            : mul_prod[WIDTH-1:0];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .start   (acc && is_mul(op)),
    .a       (in_a),
    .b       (in_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    add_s   = {1'b0, in_a} + {1'b0, in_b};
    sub_s   = {1'b0, in_a} - {1'b0, in_b};
    case (op)
      OP_ADD: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c   = add_s[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                  (add_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c   = sub_s[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                  (sub_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SRL:  alu_res = in_a >> in_shamt;
      OP_SLL:  alu_res = in_a << in_shamt;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(in_a) < $signed(in_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      OP_SRA:  alu_res = $signed(in_a) >>> in_shamt;
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (acc) state_n = is_mul(op) ? MUL : RESP;
      MUL: begin
        if (mul_done)      state_n = RESP;
        else if (!mul_busy) state_n = IDLE;
      end
      RESP: begin
        if (acc)            state_n = is_mul(op) ? MUL : RESP;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_tag    <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      mul_hi     <= 1'b0;
      mul_tag    <= '0;
    end else if (flush) begin
      out_result <= '0;
      out_tag    <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      mul_hi     <= 1'b0;
      mul_tag    <= '0;
    end else if (acc && !is_mul(op)) begin
      out_result <= alu_res;
      out_tag    <= in_tag;
      out_zero   <= (alu_res == '0);
      out_carry  <= alu_c;
      out_ovf    <= alu_v;
    end else if (acc) begin
      mul_hi  <= (op == OP_MULHU);
      mul_tag <= in_tag;
    end else if ((state == MUL) && mul_done) begin
      out_result <= mul_res;
      out_tag    <= mul_tag;
      out_zero   <= (mul_res == '0);
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Directed and randomized checks of pipe_alu against an arithmetic model.
// WIDTH=32; inputs driven and outputs sampled 1ns after rising edges.
module tb_pipe_alu;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [4:0]    in_shamt;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_zero;
  logic          out_carry;
  logic          out_ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_alu #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {carry, ovf, result} from plain integer arithmetic
  function automatic logic [33:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [4:0] sh);
    logic [63:0] p;
    logic [63:0] s;
    longint      sv;
    logic [31:0] r;
    logic        c;
    logic        v;
    r  = 0;
    c  = 0;
    v  = 0;
    p  = 64'(a) * 64'(b);
    s  = 64'(a) + 64'(b);
    sv = 0;
    case (op)
      4'd0: begin
        r  = s[31:0];
        c  = s[32];
        sv = longint'($signed(a)) + longint'($signed(b));
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd1: begin
        r  = a - b;
        c  = (a < b);
        sv = longint'($signed(a)) - longint'($signed(b));
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd2:  r = p[31:0];
      4'd3:  r = a >> sh;
      4'd4:  r = a << sh;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  r = a ^ b;
      4'd10: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd11: r = p[63:32];
      default: r = 0;
    endcase
    return {c, v, r};
  endfunction

  // Issue one op with out_ready=1 and check its result against the model
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [TW-1:0] tag,
                        output logic [31:0] res);
    logic [33:0] e;
    int lat;
    e = model(op, a, b, sh);
    out_ready = 1'b1;
    chk("ready_before_issue", in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_shamt = sh;
    in_tag   = tag;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (op == 4'd2 || op == 4'd11) begin
      lat = 0;
      while (!out_valid && lat < 40) begin
        chk("mul_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        lat++;
      end
      chk("mul_latency", lat, W);
    end
    chk("valid", out_valid, 1);
    chk("result", out_result, e[31:0]);
    chk("tag", out_tag, tag);
    chk("carry", out_carry, e[33]);
    chk("ovf", out_ovf, e[32]);
    chk("zero", out_zero, e[31:0] == 0);
    res = out_result;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    logic [33:0] e;
    int          seen;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_shamt  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {out_zero, out_carry, out_ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    run_op(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd3, r);
    chk("add_ovf_const", {r, out_ovf, out_carry, out_zero},
        {32'h8000_0000, 3'b100});
    chk("add_tag_const", out_tag, 3);

    // Reset pulsed on the 5th cycle of a multiply
    in_valid = 1'b1;
    in_op    = 4'd2;
    in_a     = 32'd3;
    in_b     = 32'd4;
    in_tag   = 5'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("midmul_rst_valid", out_valid, 0);
    chk("midmul_rst_ready", in_ready, 1);
    chk("midmul_rst_result", out_result, 0);
    chk("midmul_rst_tag", out_tag, 0);
    chk("midmul_rst_flags", {out_zero, out_carry, out_ovf}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midmul_no_late_valid", out_valid, 0);

    run_op(4'd1, 32'd5, 32'd5, 5'd0, 5'd1, r);
    chk("sub_zero_const", {r, out_zero, out_carry}, {32'h0, 2'b10});
    run_op(4'd1, 32'd3, 32'd5, 5'd0, 5'd2, r);
    chk("sub_borrow_const", {r, out_carry}, {32'hFFFF_FFFE, 1'b1});
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd4, r);
    chk("slt_const", r, 1);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd5, r);
    chk("sltu_const", r, 0);
    run_op(4'd10, 32'h8000_0000, 32'h1234, 5'd4, 5'd6, r);
    chk("sra_const", r, 32'hF800_0000);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd7, r);
    chk("mul_lo_const", r, 32'h0000_0001);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd8, r);
    chk("mulhu_const", r, 32'hFFFF_FFFE);
    run_op(4'd13, 32'hDEAD_BEEF, 32'h1, 5'd3, 5'd11, r);
    chk("illegal_op_const", {r, out_carry, out_ovf}, {32'h0, 2'b00});

    // Flush on the 10th multiply cycle
    in_valid = 1'b1;
    in_op    = 4'd11;
    in_a     = 32'h1234_5678;
    in_b     = 32'h9ABC_DEF0;
    in_tag   = 5'd12;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("preflush_ready", in_ready, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);

    // Backpressure: hold for 3 cycles, then 4 back-to-back ADDs
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 4'd0;
    in_a      = 32'd10;
    in_b      = 32'd20;
    in_tag    = 5'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_first", out_result, 30);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 30);
      chk("bp_hold_tag", out_tag, 7);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_op    = 4'd0;
      in_a     = 32'(i * 100 + 1);
      in_b     = 32'(i);
      in_tag   = 5'(i + 10);
      @(posedge clk);
      #1;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_result", out_result, 32'(i * 101 + 1));
      chk("b2b_tag", out_tag, 5'(i + 10));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_drain", out_valid, 0);

    // Randomized ops, biased toward corner operands
    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(0, 5) == 0) rb = ra;
      e = model(rop, ra, rb, 5'($urandom_range(0, 31)));
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
